// File: rtl/ram_port_arbiter_if.sv
// Port bundle for ram_port_arbiter: two requester channels, read responses
// and the drive/return signals of the shared single-port RAM.
interface ram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int WIDTH      = 32
);
   logic [1:0]              req_valid;
   logic [1:0]              req_lock;
   logic [1:0]              req_we;
   logic [2*ADDR_WIDTH-1:0] req_addr;
   logic [2*WIDTH-1:0]      req_wdata;
   logic [1:0]              req_ready;
   logic [1:0]              rsp_valid;
   logic [WIDTH-1:0]        rsp_data;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic                    ram_we;
   logic [WIDTH-1:0]        ram_wdata;
   logic [WIDTH-1:0]        ram_rdata;

   // Arbiter side.
   modport slave (
      input  req_valid, req_lock, req_we, req_addr, req_wdata, ram_rdata,
      output req_ready, rsp_valid, rsp_data, ram_addr, ram_we, ram_wdata
   );

   // Requester / RAM side.
   modport master (
      output req_valid, req_lock, req_we, req_addr, req_wdata, ram_rdata,
      input  req_ready, rsp_valid, rsp_data, ram_addr, ram_we, ram_wdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter with burst lock in front of one single-port
// synchronous RAM; read data is routed back to its issuer one cycle later.
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int WIDTH      = 32,
   parameter int MAX_BURST  = 16
) (
   input logic               clk,
   input logic               rst_n,
   ram_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_e;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_e                state_q, state_d;
   logic                  rr_last_q, rr_last_d;
   logic [7:0]            burst_cnt_q, burst_cnt_d;
   logic                  rd_pend_q, rd_pend_d;
   logic                  rd_owner_q, rd_owner_d;

   logic                  gnt_vld;
   logic                  gnt_idx;
   logic                  gnt_act;
   logic                  xfer;
   logic                  xfer_lock;
   logic                  rsp_act;
   logic [7:0]            cnt_base;
   logic [ADDR_WIDTH-1:0] gnt_addr;
   logic [WIDTH-1:0]      gnt_wdata;

   function automatic state_e own_state(input logic r);
      return r ? OWN1 : OWN0;
   endfunction

   // Owner keeps the port while it stays valid; otherwise plain round-robin.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = 1'b0;
      if (state_q == OWN0 && bus.req_valid[0]) begin
         gnt_vld = 1'b1;
         gnt_idx = 1'b0;
      end else if (state_q == OWN1 && bus.req_valid[1]) begin
         gnt_vld = 1'b1;
         gnt_idx = 1'b1;
      end else if (bus.req_valid == 2'b11) begin
         gnt_vld = 1'b1;
         gnt_idx = ~rr_last_q;
      end else if (bus.req_valid[0]) begin
         gnt_vld = 1'b1;
         gnt_idx = 1'b0;
      end else if (bus.req_valid[1]) begin
         gnt_vld = 1'b1;
         gnt_idx = 1'b1;
      end
   end

   assign gnt_act   = gnt_vld & rst_n;
   assign xfer      = gnt_act & bus.req_valid[gnt_idx];
   assign xfer_lock = xfer & bus.req_lock[gnt_idx];

   assign gnt_addr  = gnt_idx ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                              : bus.req_addr[ADDR_WIDTH-1:0];
   assign gnt_wdata = gnt_idx ? bus.req_wdata[2*WIDTH-1:WIDTH]
                              : bus.req_wdata[WIDTH-1:0];

   assign bus.req_ready = {gnt_act & gnt_idx, gnt_act & ~gnt_idx};
   assign bus.ram_addr  = gnt_act ? gnt_addr : '0;
   assign bus.ram_wdata = gnt_act ? gnt_wdata : '0;
   assign bus.ram_we    = xfer & bus.req_we[gnt_idx];

   // Gating with rst_n drops a response whose read was accepted just before reset.
   assign rsp_act       = rd_pend_q & rst_n;
   assign bus.rsp_valid = {rsp_act & rd_owner_q, rsp_act & ~rd_owner_q};
   assign bus.rsp_data  = rsp_act ? bus.ram_rdata : '0;

   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      burst_cnt_d = burst_cnt_q;
      rd_pend_d   = xfer & ~bus.req_we[gnt_idx];
      rd_owner_d  = rd_pend_d ? gnt_idx : rd_owner_q;
      // A lock taken over from another state starts a fresh burst count.
      cnt_base    = (state_q == own_state(gnt_idx)) ? burst_cnt_q : 8'd0;
      if (xfer) begin
         rr_last_d = gnt_idx;
         if (xfer_lock && cnt_base != BURST_LAST) begin
            state_d     = own_state(gnt_idx);
            burst_cnt_d = cnt_base + 8'd1;
         end else begin
            state_d     = IDLE;
            burst_cnt_d = 8'd0;
         end
      end else if (state_q != IDLE) begin
         state_d     = IDLE;
         burst_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_last_q   <= 1'b1;
         burst_cnt_q <= 8'd0;
         rd_pend_q   <= 1'b0;
         rd_owner_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         burst_cnt_q <= burst_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rd_owner_q  <= rd_owner_d;
      end
   end

   a_one_ready: assert property (@(posedge clk) $onehot0(bus.req_ready));
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, response scoreboard and one task
// per scenario.
module tb_ram_port_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ram_port_arbiter_if #(.ADDR_WIDTH(AW), .WIDTH(DW)) bus ();

   ram_port_arbiter #(.ADDR_WIDTH(AW), .WIDTH(DW), .MAX_BURST(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   function automatic logic [31:0] pat(input logic [11:0] a);
      return 32'hC0DE_0000 | {20'h0, a};
   endfunction

   // Behavioural single-port RAM: one cycle read latency.
   logic [31:0] mem    [0:4095];
   bit          mem_wr [0:4095];
   always @(posedge clk) begin
      if (bus.ram_we === 1'b1) begin
         mem[bus.ram_addr]    <= bus.ram_wdata;
         mem_wr[bus.ram_addr] <= 1'b1;
      end
      bus.ram_rdata <= mem_wr[bus.ram_addr] ? mem[bus.ram_addr] : pat(bus.ram_addr);
   end

   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] shadow [0:4095];
   bit          sh_wr  [0:4095];

   typedef struct {
      int          cyc;
      logic [1:0]  vld;
      logic [31:0] data;
   } rsp_t;
   rsp_t sb[$];

   // Response monitor: a read accepted in cycle k must answer in cycle k+1 only.
   rsp_t        mon_e;
   logic [1:0]  mon_v;
   logic [31:0] mon_d;
   always @(negedge clk) begin
      if (mon_en) begin
         mon_v = 2'b00;
         mon_d = 32'h0;
         while (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL rsp_stale: entry from cycle %0d never consumed", mon_e.cyc);
         end
         if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
            mon_e = sb.pop_front();
            mon_v = mon_e.vld;
            mon_d = mon_e.data;
         end
         checks++;
         if (bus.rsp_valid !== mon_v || bus.rsp_data !== mon_d) begin
            errors++;
            $display("FAIL rsp_scoreboard cyc %0d: got v=%b d=%h want v=%b d=%h",
                     cyc, bus.rsp_valid, bus.rsp_data, mon_v, mon_d);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic v, input logic lk, input logic we,
                          input logic [11:0] a, input logic [31:0] wd);
      bus.req_valid[r]          = v;
      bus.req_lock[r]           = lk;
      bus.req_we[r]             = we;
      bus.req_addr[r*AW +: AW]  = a;
      bus.req_wdata[r*DW +: DW] = wd;
   endtask

   task automatic idle_all();
      set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
      set_req(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
   endtask

   task automatic sb_accept(input logic r, input logic we, input logic [11:0] a,
                            input logic [31:0] wd);
      rsp_t e;
      if (we) begin
         shadow[a] = wd;
         sh_wr[a]  = 1'b1;
      end else begin
         e.cyc  = cyc;
         e.vld  = r ? 2'b10 : 2'b01;
         e.data = sh_wr[a] ? shadow[a] : pat(a);
         sb.push_back(e);
      end
   endtask

   task automatic do_reset();
      sb.delete();
      idle_all();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      set_req(0, 1'b1, 1'b0, 1'b1, 12'h7, 32'h1234);
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h8, 32'h0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 2'b00 || bus.ram_we !== 1'b0 || bus.ram_addr !== 12'h0) begin
            errors++;
            $display("FAIL reset_req cycle %0d: ready=%b we=%b addr=%h want 00/0/000",
                     i, bus.req_ready, bus.ram_we, bus.ram_addr);
         end
         checks++;
         if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp cycle %0d: v=%b d=%h want 00/0", i, bus.rsp_valid, bus.rsp_data);
         end
         tick();
      end
      rst_n  = 1'b1;
      mon_en = 1'b1;
      set_req(0, 1'b1, 1'b0, 1'b0, 12'h7, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_tie: ready=%b want 01", bus.req_ready);
      end
      sb_accept(1'b0, 1'b0, 12'h7, 32'h0);
      tick();
      idle_all();
      tick();
   endtask

   task automatic test_write_read();
      do_reset();
      set_req(0, 1'b1, 1'b0, 1'b1, 12'h005, 32'h3F80_0000);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01 || bus.ram_we !== 1'b1 || bus.ram_addr !== 12'h005 ||
          bus.ram_wdata !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL wr_drive: ready=%b we=%b addr=%h wd=%h want 01/1/005/3f800000",
                  bus.req_ready, bus.ram_we, bus.ram_addr, bus.ram_wdata);
      end
      sb_accept(1'b0, 1'b1, 12'h005, 32'h3F80_0000);
      tick();
      set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h005, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10 || bus.ram_we !== 1'b0 || bus.ram_addr !== 12'h005) begin
         errors++;
         $display("FAIL rd_drive: ready=%b we=%b addr=%h want 10/0/005",
                  bus.req_ready, bus.ram_we, bus.ram_addr);
      end
      sb_accept(1'b1, 1'b0, 12'h005, 32'h0);
      tick();
      idle_all();
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'h3F80_0000) begin
         errors++;
         $display("FAIL rd_rsp: v=%b d=%h want 10/3f800000", bus.rsp_valid, bus.rsp_data);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [11:0] a0, a1;
      logic [1:0]  exp;
      do_reset();
      a0 = 12'h010;
      a1 = 12'h020;
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b1, 1'b0, 1'b1, a0, 32'hA000_0000 + i);
         set_req(1, 1'b1, 1'b0, 1'b0, a1, 32'h0);
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if (bus.req_ready !== exp) begin
            errors++;
            $display("FAIL rr_grant %0d: ready=%b want %b", i, bus.req_ready, exp);
         end
         if (exp == 2'b01) begin
            sb_accept(1'b0, 1'b1, a0, 32'hA000_0000 + i);
            a0++;
         end else begin
            sb_accept(1'b1, 1'b0, a1, 32'h0);
            a1++;
         end
         tick();
      end
      idle_all();
      tick();
   endtask

   task automatic test_burst_lock();
      logic [11:0] a0, a1;
      logic [1:0]  exp;
      do_reset();
      a0 = 12'h200;
      a1 = 12'h100;
      for (int i = 0; i < 22; i++) begin
         set_req(0, (i >= 1), 1'b0, 1'b1, a0, 32'h5000_0000 + i);
         set_req(1, 1'b1, 1'b1, 1'b0, a1, 32'h0);
         exp = (i == 16) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if (bus.req_ready !== exp) begin
            errors++;
            $display("FAIL burst_grant %0d: ready=%b want %b", i, bus.req_ready, exp);
         end
         if (exp == 2'b01) begin
            sb_accept(1'b0, 1'b1, a0, 32'h5000_0000 + i);
            a0++;
         end else begin
            sb_accept(1'b1, 1'b0, a1, 32'h0);
            a1++;
         end
         tick();
      end
      idle_all();
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'hA;
      vals[1] = 32'hB;
      vals[2] = 32'hC;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         set_req(0, 1'b1, 1'b0, 1'b1, 12'(i), vals[i]);
         @(negedge clk);
         checks++;
         if (bus.req_ready !== 2'b01 || bus.ram_we !== 1'b1) begin
            errors++;
            $display("FAIL preload %0d: ready=%b we=%b want 01/1", i, bus.req_ready, bus.ram_we);
         end
         sb_accept(1'b0, 1'b1, 12'(i), vals[i]);
         tick();
      end
      set_req(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         set_req(1, (i < 3), 1'b0, 1'b0, 12'(i), 32'h0);
         @(negedge clk);
         if (i < 3) begin
            checks++;
            if (bus.req_ready !== 2'b10) begin
               errors++;
               $display("FAIL b2b_ready %0d: ready=%b want 10", i, bus.req_ready);
            end
            sb_accept(1'b1, 1'b0, 12'(i), 32'h0);
         end
         if (i > 0) begin
            checks++;
            if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== vals[i-1]) begin
               errors++;
               $display("FAIL b2b_rsp %0d: v=%b d=%h want 10/%h",
                        i - 1, bus.rsp_valid, bus.rsp_data, vals[i-1]);
            end
         end
         tick();
      end
      idle_all();
      tick();
   endtask

   task automatic test_reset_drop();
      do_reset();
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h050, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL drop_read_ready: ready=%b want 10", bus.req_ready);
      end
      tick();
      rst_n = 1'b0;
      set_req(0, 1'b1, 1'b0, 1'b0, 12'h060, 32'h0);
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h061, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.rsp_data !== 32'h0 || bus.req_ready !== 2'b00) begin
         errors++;
         $display("FAIL drop_in_reset: v=%b d=%h ready=%b want 00/0/00",
                  bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL drop_after: ready=%b v=%b want 01/00", bus.req_ready, bus.rsp_valid);
      end
      sb_accept(1'b0, 1'b0, 12'h060, 32'h0);
      tick();
      idle_all();
      tick();
   endtask

   task automatic test_lock_drop();
      do_reset();
      // A: req0 takes a locked write
      set_req(0, 1'b1, 1'b1, 1'b1, 12'h300, 32'h1111_1111);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01 || bus.ram_we !== 1'b1) begin
         errors++;
         $display("FAIL lock_a: ready=%b we=%b want 01/1", bus.req_ready, bus.ram_we);
      end
      sb_accept(1'b0, 1'b1, 12'h300, 32'h1111_1111);
      tick();
      // B: req0 drops valid with lock and we still set; req1 reads
      set_req(0, 1'b0, 1'b1, 1'b1, 12'h301, 32'h2222_2222);
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h302, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10 || bus.ram_we !== 1'b0 || bus.ram_addr !== 12'h302) begin
         errors++;
         $display("FAIL lock_b: ready=%b we=%b addr=%h want 10/0/302",
                  bus.req_ready, bus.ram_we, bus.ram_addr);
      end
      sb_accept(1'b1, 1'b0, 12'h302, 32'h0);
      tick();
      // C: tie after req1 won goes to req0
      set_req(0, 1'b1, 1'b1, 1'b1, 12'h303, 32'h3333_3333);
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h304, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b01) begin
         errors++;
         $display("FAIL lock_c: ready=%b want 01", bus.req_ready);
      end
      sb_accept(1'b0, 1'b1, 12'h303, 32'h3333_3333);
      tick();
      // D: owner idles with nobody else valid
      set_req(0, 1'b0, 1'b1, 1'b1, 12'h3FF, 32'h0);
      set_req(1, 1'b0, 1'b0, 1'b0, 12'h3FE, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b00 || bus.ram_we !== 1'b0 || bus.ram_addr !== 12'h000) begin
         errors++;
         $display("FAIL lock_d: ready=%b we=%b addr=%h want 00/0/000",
                  bus.req_ready, bus.ram_we, bus.ram_addr);
      end
      tick();
      // E: lock released, so the tie follows round-robin to req1
      set_req(0, 1'b1, 1'b1, 1'b1, 12'h305, 32'h5555_5555);
      set_req(1, 1'b1, 1'b0, 1'b0, 12'h306, 32'h0);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 2'b10) begin
         errors++;
         $display("FAIL lock_e: ready=%b want 10", bus.req_ready);
      end
      sb_accept(1'b1, 1'b0, 12'h306, 32'h0);
      tick();
      idle_all();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle_all();
      test_reset();
      test_write_read();
      test_round_robin();
      test_burst_lock();
      test_back_to_back();
      test_reset_drop();
      test_lock_drop();
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
